// File: rtl/nr_div_pkg.sv
// Shared types and helpers for the non-restoring divider: state encoding and
// a width-generic conditional negate.
package nr_div_pkg;

  localparam logic [1:0] StIdleCode = 2'd0;
  localparam logic [1:0] StIterCode = 2'd1;
  localparam logic [1:0] StFixCode  = 2'd2;
  localparam logic [1:0] StDoneCode = 2'd3;

  typedef enum logic [1:0] {
    StIdle = StIdleCode,
    StIter = StIterCode,
    StFix  = StFixCode,
    StDone = StDoneCode
  } nr_div_state_e;

  localparam int unsigned NrDivMaxWidth = 1024;

  // Callers zero-extend into the max width and keep the low WIDTH bits; negation
  // modulo 2^1024 truncates to negation modulo 2^WIDTH.
  function automatic logic [NrDivMaxWidth-1:0] abs_w(input logic [NrDivMaxWidth-1:0] x,
                                                     input logic                     neg);
    return neg ? (~x + NrDivMaxWidth'(1)) : x;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division step over the {P,Q} pair: shift, add/subtract the
// divisor according to the sign of P, and produce the new quotient bit.
module nr_div_step #(
  parameter int unsigned WIDTH = 233
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] p_sh;

  // The shift may overflow WIDTH+1 bits; modular arithmetic still lands the
  // result back in [-D, D).
  assign p_sh    = {p_i[WIDTH-1:0], q_msb_i};
  assign p_o     = p_i[WIDTH] ? (p_sh + {1'b0, d_i}) : (p_sh - {1'b0, d_i});
  assign q_bit_o = ~p_o[WIDTH];

endmodule

// File: rtl/nr_divider.sv
// Sequential radix-2 non-restoring divider, one quotient bit per clock.
// Define NR_DIV_SIGNED_EN for two's-complement operands (truncating division).
module nr_divider
  import nr_div_pkg::*;
#(
  parameter int unsigned WIDTH = 233,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             dz_o
);

  nr_div_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   step_p;
  logic             step_qbit;
  logic [WIDTH-1:0] a_mag, b_mag, rem_mag, rem_src, q_res, r_res;

  nr_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_i     (p_q),
    .q_msb_i (quo_q[WIDTH-1]),
    .d_i     (d_q),
    .p_o     (step_p),
    .q_bit_o (step_qbit)
  );

  assign rem_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
  // On divide-by-zero the untouched quotient register still holds |a|.
  assign rem_src = bz_q ? quo_q : rem_mag;

`ifdef NR_DIV_SIGNED_EN
  logic                     sa_q, sa_d, neg_q, neg_d;
  logic [NrDivMaxWidth-1:0] a_abs, b_abs, q_fix, r_fix;

  assign a_abs = abs_w(NrDivMaxWidth'(a_i), a_i[WIDTH-1]);
  assign b_abs = abs_w(NrDivMaxWidth'(b_i), b_i[WIDTH-1]);
  assign q_fix = abs_w(NrDivMaxWidth'(quo_q), neg_q);
  assign r_fix = abs_w(NrDivMaxWidth'(rem_src), sa_q);
  assign a_mag = a_abs[WIDTH-1:0];
  assign b_mag = b_abs[WIDTH-1:0];
  assign q_res = q_fix[WIDTH-1:0];
  assign r_res = r_fix[WIDTH-1:0];
  assign sa_d  = (state_q == StIdle && start_i) ? a_i[WIDTH-1] : sa_q;
  assign neg_d = (state_q == StIdle && start_i) ? (a_i[WIDTH-1] ^ b_i[WIDTH-1]) : neg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      neg_q <= neg_d;
    end
  end
`else
  assign a_mag = a_i;
  assign b_mag = b_i;
  assign q_res = quo_q;
  assign r_res = rem_src;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    quo_d   = quo_q;
    d_d     = d_q;
    bz_d    = bz_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_o  = 1'b0;
    busy_o  = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          d_d     = b_mag;
          quo_d   = a_mag;
          p_d     = '0;
          bz_d    = (b_i == '0);
          cnt_d   = CNT_W'(WIDTH);
          state_d = (b_i == '0) ? StFix : StIter;
        end
      end
      StIter: begin
        p_d   = step_p;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        q_d     = bz_q ? '1 : q_res;
        r_d     = r_res;
        dz_d    = bz_q;
        state_d = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      d_q     <= '0;
      bz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      d_q     <= d_d;
      bz_q    <= bz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign q_o  = q_q;
  assign r_o  = r_q;
  assign dz_o = dz_q;

endmodule

// File: tb/tb_nr_divider.sv
// Directed bench for nr_divider: 8-bit and 233-bit instances, latency,
// divide-by-zero, handshake corner cases and mid-operation reset.
module tb_nr_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  logic       busy8, done8, dz8;

  logic         start233 = 1'b0;
  logic [232:0] a233 = '0, b233 = '0, q233, r233;
  logic         busy233, done233, dz233;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nr_divider #(
    .WIDTH (8)
  ) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start8),
    .a_i     (a8),
    .b_i     (b8),
    .busy_o  (busy8),
    .done_o  (done8),
    .q_o     (q8),
    .r_o     (r8),
    .dz_o    (dz8)
  );

  nr_divider #(
    .WIDTH (233)
  ) u_dut233 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start233),
    .a_i     (a233),
    .b_i     (b233),
    .busy_o  (busy233),
    .done_o  (done233),
    .q_o     (q233),
    .r_o     (r233),
    .dz_o    (dz233)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz,
                      input int elat);
    int lat;
    lat = 0;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (i == 1) chk({tag, ".busy"}, busy8, 1);
      if (done8) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".q"}, q8, eq);
    chk({tag, ".r"}, r8, er);
    chk({tag, ".dz"}, dz8, edz);
  endtask

  task automatic run233(input string tag, input logic [232:0] a, input logic [232:0] b,
                        input logic [232:0] eq, input logic [232:0] er);
    int lat;
    lat = 0;
    @(negedge clk);
    a233 = a; b233 = b; start233 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start233 = 1'b0;
      if (done233) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".lat"}, lat, 235);
    chk({tag, ".q"}, q233, eq);
    chk({tag, ".r"}, r233, er);
    chk({tag, ".dz"}, dz233, 0);
  endtask

  initial begin
    logic [232:0] max232, one233, p200;
    int lat, first, second, idle_cnt, ndone;

    max232 = '0;
    for (int i = 0; i < 232; i++) max232[i] = 1'b1;
    one233 = '0;
    one233[0] = 1'b1;
    p200 = '0;
    p200[200] = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", busy8, 0);
    chk("rst.done", done8, 0);
    chk("rst.q", q8, 0);
    chk("rst.r", r8, 0);
    chk("rst.dz", dz8, 0);
    rst = 1'b0;

`ifdef NR_DIV_SIGNED_EN
    run8("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10);
    run8("s_7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 10);
    run8("s_ovf", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10);
    run8("s_dz", 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 2);
    run8("s_dzneg", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 2);
    run8("s_clr", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 10);
`else
    run8("u_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 10);
    run8("u_dz", 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 2);
    run8("u_clr", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 10);
    run8("u_ff_ff", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 10);
    run8("u_3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 10);
    run8("u_ff_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 10);

    // start pulsed during ITER must be ignored and not queue
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    for (int i = 5; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
    chk("ign.lat", lat, 10);
    chk("ign.q", q8, 28);
    chk("ign.r", r8, 4);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("ign.noqueue", ndone, 0);

    // start held high: back-to-back with one IDLE cycle between
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    first = 0; second = 0; idle_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done8) begin
        if (first == 0) first = i;
        else begin
          second = i;
          start8 = 1'b0;
          break;
        end
      end else if (!busy8 && first != 0) begin
        idle_cnt++;
      end
    end
    chk("hold.first", first, 10);
    chk("hold.gap", second - first, 11);
    chk("hold.idle", idle_cnt, 1);
    chk("hold.q", q8, 28);
`endif

    run233("w_max_1", max232, one233, max232, '0);
    run233("w_5_p200", 233'd5, p200, '0, 233'd5);
    run233("w_max_1b", max232, one233, max232, '0);

    // reset during iteration 100 aborts without a done pulse
    @(negedge clk);
    a233 = 233'd5; b233 = p200; start233 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start233 = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.busy", busy233, 0);
    chk("mrst.done", done233, 0);
    chk("mrst.q", q233, 0);
    chk("mrst.r", r233, 0);
    chk("mrst.dz", dz233, 0);
    ndone = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (done233) ndone++;
    end
    chk("mrst.nodone", ndone, 0);
    run233("w_after", 233'd5, p200, '0, 233'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
